// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage pipeline.
// It produces E-stage forwarding selects and detects load-use hazards with a
// per-register countdown scoreboard. It also handles branch-redirect flushes and
// runs a halt-drain FSM that brings the pipeline to a clean stop.
//
//   state  | meaning
//   RUN    | normal issue; load-use stalls and redirects handled
//   DRAIN  | halt issued; F/D held while E/M/W empty out
//   HALTED | pipeline stopped; held until reset
module hazard_scoreboard #(
  parameter int REG_AW       = 5,
  parameter int LOAD_USE_CYC = 1,
  parameter int HALT_DRAIN   = 3,
  parameter int CNT_W        = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              validD_i,
  input  logic [REG_AW-1:0] rs1D_i,
  input  logic [REG_AW-1:0] rs2D_i,
  input  logic              usesrs1D_i,
  input  logic              usesrs2D_i,
  input  logic [REG_AW-1:0] rdD_i,
  input  logic              memtoregD_i,
  input  logic              haltD_i,
  input  logic [REG_AW-1:0] rs1E_i,
  input  logic [REG_AW-1:0] rs2E_i,
  input  logic              usesrs1E_i,
  input  logic              usesrs2E_i,
  input  logic [REG_AW-1:0] rdM_i,
  input  logic [REG_AW-1:0] rdW_i,
  input  logic              writesregM_i,
  input  logic              writesregW_i,
  input  logic              redirectM_i,
  output logic [1:0]        forwardAE_o,
  output logic [1:0]        forwardBE_o,
  output logic              stallF_o,
  output logic              stallD_o,
  output logic              flushD_o,
  output logic              flushE_o,
  output logic              flushM_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int NREG = 2 ** REG_AW;
  localparam int DW   = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  localparam logic [1:0]    LUC       = 2'(LOAD_USE_CYC);
  localparam logic [DW-1:0] DRAIN_TOP = DW'(HALT_DRAIN - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [1:0]        sb_q [NREG];
  logic [1:0]        sb_d [NREG];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              ldE_q, ldE_d;
  logic              ldM_q, ldM_d;

  logic              loaduse;
  logic              issueD;
  logic              load_set;

  // Forwarding select: M result is newer than W, so M wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic              uses,
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdm,
    input logic              wm,
    input logic [REG_AW-1:0] rdw,
    input logic              ww
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && (rs != '0)) begin
      if (wm && (rdm == rs))      sel = 2'b10;
      else if (ww && (rdw == rs)) sel = 2'b01;
    end
    return sel;
  endfunction

  // E-stage operand forwarding selects
  always_comb begin
    forwardAE_o = fwd_sel(usesrs1E_i, rs1E_i, rdM_i, writesregM_i, rdW_i, writesregW_i);
    forwardBE_o = fwd_sel(usesrs2E_i, rs2E_i, rdM_i, writesregM_i, rdW_i, writesregW_i);
  end

  // Load-use detection and issue qualification
  always_comb begin
    loaduse  = validD_i &&
               ((usesrs1D_i && (sb_q[rs1D_i] != 2'd0)) ||
                (usesrs2D_i && (sb_q[rs2D_i] != 2'd0)));
    issueD   = validD_i && !loaduse && !redirectM_i && (state_q == RUN);
    load_set = issueD && memtoregD_i && (rdD_i != '0);
  end

  // Scoreboard next state: a redirect kills every tracked load because all of them are younger than the branch
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      sb_d[r] = sb_q[r];
      if (redirectM_i) begin
        sb_d[r] = 2'd0;
      end else if (load_set && (rdD_i == REG_AW'(r))) begin
        sb_d[r] = LUC;
      end else if (sb_q[r] != 2'd0) begin
        sb_d[r] = sb_q[r] - 2'd1;
      end
    end
    sb_d[0] = 2'd0;
  end

  // FSM next state and pipeline control outputs; a redirect overrides stalls and cancels a drain
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    stallF_o = 1'b0;
    stallD_o = 1'b0;
    flushD_o = 1'b0;
    flushE_o = 1'b0;
    flushM_o = 1'b0;
    unique case (state_q)
      RUN: begin
        stallF_o = loaduse;
        stallD_o = loaduse;
        flushE_o = loaduse;
        if (issueD && haltD_i) begin
          state_d = DRAIN;
          drain_d = DRAIN_TOP;
        end
      end
      DRAIN: begin
        stallF_o = 1'b1;
        stallD_o = 1'b1;
        flushE_o = 1'b1;
        if (drain_q == '0) state_d = HALTED;
        else               drain_d = drain_q - 1'b1;
      end
      HALTED: begin
        stallF_o = 1'b1;
        stallD_o = 1'b1;
        flushE_o = 1'b1;
      end
      default: begin
        state_d = RUN;
        drain_d = '0;
      end
    endcase
    if (redirectM_i) begin
      stallF_o = 1'b0;
      stallD_o = 1'b0;
      flushD_o = 1'b1;
      flushE_o = 1'b1;
      flushM_o = 1'b1;
      if (state_q == DRAIN) begin
        state_d = RUN;
        drain_d = '0;
      end
    end
  end

  // Performance counters; both freeze once the pipeline has halted
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == RUN) && loaduse && !redirectM_i) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((state_q != HALTED) && redirectM_i)          flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Track which of E/M holds a load, used only by the forwarding invariant below
  always_comb begin
    ldE_d = issueD && memtoregD_i;
    ldM_d = ldE_q && !redirectM_i;
  end

  // State, scoreboard and counter registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      ldE_q       <= 1'b0;
      ldM_q       <= 1'b0;
      for (int r = 0; r < NREG; r++) sb_q[r] <= 2'd0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      ldE_q       <= ldE_d;
      ldM_q       <= ldM_d;
      for (int r = 0; r < NREG; r++) sb_q[r] <= sb_d[r];
    end
  end

  assign halted_o    = (state_q == HALTED);
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  // A load in M has no data yet, so the scoreboard must keep any consumer out of E
  a_no_fwd_from_load: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(ldM_q && ((forwardAE_o == 2'b10) || (forwardBE_o == 2'b10))));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding vector table plus
// hand-written load-use, redirect, halt-drain and reset sequences.
module tb_hazard_scoreboard;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       validD_i, usesrs1D_i, usesrs2D_i, memtoregD_i, haltD_i;
  logic [4:0] rs1D_i, rs2D_i, rdD_i, rs1E_i, rs2E_i, rdM_i, rdW_i;
  logic       usesrs1E_i, usesrs2E_i, writesregM_i, writesregW_i, redirectM_i;

  logic [1:0]  a_fwdA, a_fwdB, b_fwdA, b_fwdB;
  logic        a_stF, a_stD, a_flD, a_flE, a_flM, a_halt;
  logic        b_stF, b_stD, b_flD, b_flE, b_flM, b_halt;
  logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  hazard_scoreboard #(.REG_AW(5), .LOAD_USE_CYC(1), .HALT_DRAIN(3), .CNT_W(32)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .validD_i(validD_i), .rs1D_i(rs1D_i), .rs2D_i(rs2D_i),
    .usesrs1D_i(usesrs1D_i), .usesrs2D_i(usesrs2D_i), .rdD_i(rdD_i), .memtoregD_i(memtoregD_i),
    .haltD_i(haltD_i), .rs1E_i(rs1E_i), .rs2E_i(rs2E_i), .usesrs1E_i(usesrs1E_i),
    .usesrs2E_i(usesrs2E_i), .rdM_i(rdM_i), .rdW_i(rdW_i), .writesregM_i(writesregM_i),
    .writesregW_i(writesregW_i), .redirectM_i(redirectM_i), .forwardAE_o(a_fwdA),
    .forwardBE_o(a_fwdB), .stallF_o(a_stF), .stallD_o(a_stD), .flushD_o(a_flD),
    .flushE_o(a_flE), .flushM_o(a_flM), .halted_o(a_halt), .stall_cnt_o(a_scnt),
    .flush_cnt_o(a_fcnt));

  hazard_scoreboard #(.REG_AW(5), .LOAD_USE_CYC(2), .HALT_DRAIN(3), .CNT_W(32)) dut2 (
    .clk_i(clk_i), .reset_i(reset_i), .validD_i(validD_i), .rs1D_i(rs1D_i), .rs2D_i(rs2D_i),
    .usesrs1D_i(usesrs1D_i), .usesrs2D_i(usesrs2D_i), .rdD_i(rdD_i), .memtoregD_i(memtoregD_i),
    .haltD_i(haltD_i), .rs1E_i(rs1E_i), .rs2E_i(rs2E_i), .usesrs1E_i(usesrs1E_i),
    .usesrs2E_i(usesrs2E_i), .rdM_i(rdM_i), .rdW_i(rdW_i), .writesregM_i(writesregM_i),
    .writesregW_i(writesregW_i), .redirectM_i(redirectM_i), .forwardAE_o(b_fwdA),
    .forwardBE_o(b_fwdB), .stallF_o(b_stF), .stallD_o(b_stD), .flushD_o(b_flD),
    .flushE_o(b_flE), .flushM_o(b_flM), .halted_o(b_halt), .stall_cnt_o(b_scnt),
    .flush_cnt_o(b_fcnt));

  typedef struct {
    logic [4:0] rs1E, rs2E, rdM, rdW;
    logic       u1, u2, wM, wW;
    logic [1:0] expA, expB;
  } fwd_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    validD_i = 0; usesrs1D_i = 0; usesrs2D_i = 0; memtoregD_i = 0; haltD_i = 0;
    rs1D_i = 0; rs2D_i = 0; rdD_i = 0; rs1E_i = 0; rs2E_i = 0; rdM_i = 0; rdW_i = 0;
    usesrs1E_i = 0; usesrs2E_i = 0; writesregM_i = 0; writesregW_i = 0; redirectM_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    reset_i = 0;
    tick();
    reset_i = 1;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    clr_in();
    validD_i = 1; memtoregD_i = 1; rdD_i = rd;
  endtask

  task automatic drive_use(input logic [4:0] rs, input logic u1);
    clr_in();
    validD_i = 1; usesrs1D_i = u1; rs1D_i = rs;
  endtask

  fwd_vec_t vecs[8];

  initial begin
    vecs[0] = '{rs1E:5,  rs2E:6,  rdM:5,  rdW:0,  u1:1, u2:1, wM:1, wW:0, expA:2'b10, expB:2'b00};
    vecs[1] = '{rs1E:5,  rs2E:5,  rdM:5,  rdW:5,  u1:1, u2:1, wM:1, wW:1, expA:2'b10, expB:2'b10};
    vecs[2] = '{rs1E:0,  rs2E:0,  rdM:0,  rdW:0,  u1:1, u2:1, wM:1, wW:1, expA:2'b00, expB:2'b00};
    vecs[3] = '{rs1E:9,  rs2E:9,  rdM:9,  rdW:0,  u1:1, u2:0, wM:1, wW:0, expA:2'b10, expB:2'b00};
    vecs[4] = '{rs1E:4,  rs2E:4,  rdM:4,  rdW:4,  u1:1, u2:1, wM:0, wW:1, expA:2'b01, expB:2'b01};
    vecs[5] = '{rs1E:7,  rs2E:8,  rdM:8,  rdW:7,  u1:1, u2:1, wM:1, wW:1, expA:2'b01, expB:2'b10};
    vecs[6] = '{rs1E:0,  rs2E:3,  rdM:31, rdW:0,  u1:1, u2:1, wM:1, wW:1, expA:2'b00, expB:2'b00};
    vecs[7] = '{rs1E:12, rs2E:12, rdM:12, rdW:12, u1:0, u2:1, wM:1, wW:1, expA:2'b00, expB:2'b10};

    clr_in();
    reset_i = 0;
    tick();
    tick();
    chk("rst_halted", 32'(a_halt), 0);
    chk("rst_stall_cnt", a_scnt, 0);
    chk("rst_flush_cnt", a_fcnt, 0);
    chk("rst_stallF", 32'(a_stF), 0);
    reset_i = 1;

    // forwarding table
    for (int i = 0; i < 8; i++) begin
      clr_in();
      rs1E_i = vecs[i].rs1E; rs2E_i = vecs[i].rs2E; rdM_i = vecs[i].rdM; rdW_i = vecs[i].rdW;
      usesrs1E_i = vecs[i].u1; usesrs2E_i = vecs[i].u2;
      writesregM_i = vecs[i].wM; writesregW_i = vecs[i].wW;
      #1;
      chk($sformatf("fwdA[%0d]", i), 32'(a_fwdA), 32'(vecs[i].expA));
      chk($sformatf("fwdB[%0d]", i), 32'(a_fwdB), 32'(vecs[i].expB));
      tick();
    end

    // load-use, LOAD_USE_CYC 1 (dut1) and 2 (dut2)
    do_reset();
    drive_load(3);
    #1;
    chk("lu_issue_stallD", 32'(a_stD), 0);
    tick();
    drive_use(3, 1);
    #1;
    chk("lu1_c1_stallF", 32'(a_stF), 1);
    chk("lu1_c1_stallD", 32'(a_stD), 1);
    chk("lu1_c1_flushE", 32'(a_flE), 1);
    chk("lu2_c1_stallD", 32'(b_stD), 1);
    tick();
    #1;
    chk("lu1_c2_stallD", 32'(a_stD), 0);
    chk("lu1_c2_stall_cnt", a_scnt, 1);
    chk("lu2_c2_stallD", 32'(b_stD), 1);
    chk("lu2_c2_stall_cnt", b_scnt, 1);
    tick();
    clr_in();
    #1;
    chk("lu2_end_stall_cnt", b_scnt, 2);
    chk("lu1_end_stall_cnt", a_scnt, 1);

    // x0 load never stalls; unused source never stalls
    do_reset();
    drive_load(0);
    tick();
    drive_use(0, 1);
    #1;
    chk("x0_no_stall", 32'(a_stD), 0);
    tick();
    drive_load(6);
    tick();
    drive_use(6, 0);
    #1;
    chk("unused_src_no_stall", 32'(a_stD), 0);
    tick();

    // load-use coinciding with redirect
    do_reset();
    drive_load(3);
    tick();
    drive_use(3, 1);
    redirectM_i = 1;
    #1;
    chk("redir_stallD", 32'(a_stD), 0);
    chk("redir_stallF", 32'(a_stF), 0);
    chk("redir_flushes", {a_flD, a_flE, a_flM}, 3'b111);
    tick();
    drive_use(3, 1);
    #1;
    chk("redir_next_stallD_luc1", 32'(a_stD), 0);
    chk("redir_next_stallD_luc2", 32'(b_stD), 0);
    chk("redir_flush_cnt", a_fcnt, 1);
    chk("redir_stall_cnt", a_scnt, 0);
    tick();

    // halt drain
    do_reset();
    clr_in();
    validD_i = 1; haltD_i = 1;
    #1;
    chk("halt_issue_stallD", 32'(a_stD), 0);
    tick();
    clr_in();
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("drain%0d_halted", c), 32'(a_halt), 0);
      chk($sformatf("drain%0d_ctl", c), {a_stF, a_stD, a_flE}, 3'b111);
      tick();
    end
    chk("halted_after_drain", 32'(a_halt), 1);
    chk("halted_stallD", 32'(a_stD), 1);

    // redirect on second drain cycle squashes the halt
    do_reset();
    clr_in();
    validD_i = 1; haltD_i = 1;
    tick();
    clr_in();
    tick();
    redirectM_i = 1;
    #1;
    chk("drain_redir_stallD", 32'(a_stD), 0);
    chk("drain_redir_flushD", 32'(a_flD), 1);
    tick();
    clr_in();
    #1;
    chk("drain_redir_run_stallD", 32'(a_stD), 0);
    repeat (4) tick();
    chk("drain_redir_never_halt", 32'(a_halt), 0);
    chk("drain_redir_flush_cnt", a_fcnt, 1);

    // counters 7/2, halt, freeze, then reset
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive_load(3);
      tick();
      drive_use(3, 1);
      tick();
    end
    clr_in();
    redirectM_i = 1;
    tick();
    tick();
    clr_in();
    validD_i = 1; haltD_i = 1;
    tick();
    clr_in();
    repeat (3) tick();
    chk("seq_halted", 32'(a_halt), 1);
    chk("seq_stall_cnt", a_scnt, 7);
    chk("seq_flush_cnt", a_fcnt, 2);
    redirectM_i = 1;
    tick();
    clr_in();
    #1;
    chk("halted_flush_cnt_frozen", a_fcnt, 2);
    chk("halted_stays", 32'(a_halt), 1);
    reset_i = 0;
    tick();
    #1;
    chk("rst_from_halt_halted", 32'(a_halt), 0);
    chk("rst_from_halt_scnt", a_scnt, 0);
    chk("rst_from_halt_fcnt", a_fcnt, 0);
    chk("rst_from_halt_stallD", 32'(a_stD), 0);
    reset_i = 1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
